uart_cmd_responder: RTL and testbench

- Command engine on the user side of the UART FIFO interface. It pops received bytes from the RX FIFO, parses 2–3 byte binary read/write frames, and acts on a small register file.
- It pushes one response byte per frame into the TX FIFO.
- Sits between the uart top and board logic; register 0 drives the LEDs.

---
 rtl/uart_cmd_responder_pkg.sv | 17 +
 rtl/uart_cmd_responder_cmd_regfile.sv | 29 ++
 rtl/uart_cmd_responder.sv | 153 +++++++++++++++
 tb/tb_uart_cmd_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_responder_pkg.sv
// rtl/uart_cmd_responder_pkg.sv - shared opcodes, response bytes and FSM encoding
package uart_cmd_responder_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] ACK_DEF = 8'h06;
  localparam logic [7:0] NAK_DEF = 8'h15;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_GET_ADDR = 3'd1;
  localparam state_t ST_GET_DATA = 3'd2;
  localparam state_t ST_EXEC     = 3'd3;
  localparam state_t ST_SEND     = 3'd4;

endpackage

// File: rtl/uart_cmd_responder_cmd_regfile.sv
// rtl/uart_cmd_responder_cmd_regfile.sv - NREG x 8 register file, sync write, async read, reg0 tap
module cmd_regfile #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o,
  output logic [7:0]    reg0_o
);

  localparam int NREG = 1 << AW;

  logic [7:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else if (we_i) begin
      regs_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[addr_i];
  assign reg0_o  = regs_q[0];

endmodule

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - parses W/R frames from the RX FIFO, one response byte per frame to TX
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int         AW      = 4,
  parameter int         TIMEOUT = 100_000_000,
  parameter int         TO_BIT  = 27,
  parameter logic [7:0] ACK     = ACK_DEF,
  parameter logic [7:0] NAK     = NAK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic [7:0] reg0,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        resp_q, resp_d;
  logic [7:0]        err_q, err_d;
  logic              nak_q, nak_d;
  logic [TO_BIT-1:0] to_cnt_q, to_cnt_d;
  logic              reg_we;
  logic [7:0]        rd_val;
  logic              addr_ok;

  // Upper address bits beyond the register file must be zero.
  assign addr_ok = (addr_q >> AW) == 8'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      opcode_q <= 8'h00;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      resp_q   <= 8'h00;
      err_q    <= 8'h00;
      nak_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
      nak_q    <= nak_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    addr_d   = addr_q;
    data_d   = data_q;
    resp_d   = resp_q;
    err_d    = err_q;
    nak_d    = nak_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_empty) begin
          opcode_d = r_data;
          to_cnt_d = '0;
          if (r_data == OP_WR || r_data == OP_RD) begin
            state_d = ST_GET_ADDR;
          end else begin
            resp_d  = NAK;
            nak_d   = 1'b1;
            state_d = ST_SEND;
          end
        end
      end
      ST_GET_ADDR, ST_GET_DATA: begin
        if (!rx_empty) begin
          to_cnt_d = '0;
          if (state_q == ST_GET_ADDR) begin
            addr_d  = r_data;
            state_d = (opcode_q == OP_WR) ? ST_GET_DATA : ST_EXEC;
          end else begin
            data_d  = r_data;
            state_d = ST_EXEC;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // Abandoned frame: silently back to IDLE, nothing is reported.
          to_cnt_d = '0;
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_EXEC: begin
        state_d = ST_SEND;
        if (!addr_ok) begin
          resp_d = NAK;
          nak_d  = 1'b1;
        end else if (opcode_q == OP_WR) begin
          resp_d = ACK;
          nak_d  = 1'b0;
        end else begin
          resp_d = rd_val;
          nak_d  = 1'b0;
        end
      end
      ST_SEND: begin
        if (!tx_full) begin
          state_d = ST_IDLE;
          if (nak_q && err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    reg_we  = 1'b0;
    case (state_q)
      ST_IDLE, ST_GET_ADDR, ST_GET_DATA: rd_uart = !rx_empty;
      ST_EXEC: reg_we  = addr_ok && (opcode_q == OP_WR);
      ST_SEND: wr_uart = !tx_full;
      default: ;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign w_data  = resp_q;
  assign err_cnt = err_q;

  cmd_regfile #(.AW(AW)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we_i    (reg_we),
    .addr_i  (addr_q[AW-1:0]),
    .wdata_i (data_q),
    .rdata_o (rd_val),
    .reg0_o  (reg0)
  );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - frame table plus backpressure, timeout and reset sequences
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       tx_full = 1'b0;
  logic       rd_uart, wr_uart, busy;
  logic [7:0] w_data, reg0, err_cnt;

  always #5 clk = ~clk;

  uart_cmd_responder #(.AW(4), .TIMEOUT(50), .TO_BIT(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .reg0     (reg0),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         len;
    logic [7:0] resp;
    int         lat;
    logic [7:0] reg0;
    logic [7:0] err;
  } vec_t;

  vec_t       tbl [10];
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  int         checks = 0, errors = 0;
  int         cyc = 0, last_pop_cyc = 0, push_cyc = 0;
  int         n_pops = 0, n_pushes = 0, cur_lat = 2;
  bit         lat_chk = 1'b1;
  logic       popped = 1'b0, pushed = 1'b0;
  logic [7:0] pushed_byte = 8'h00;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    popped      <= rd_uart;
    pushed      <= wr_uart;
    pushed_byte <= w_data;
    if (rd_uart) last_pop_cyc <= cyc;
    if (wr_uart) push_cyc <= cyc;
  end

  // RX FIFO model, TX scoreboard and handshake protocol monitor.
  always @(negedge clk) begin
    if (popped) begin
      if (rx_q.size() != 0) rx_q.delete(0);
      n_pops++;
    end
    if (pushed) begin
      n_pushes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got %02h expected no push", pushed_byte);
      end else begin
        check8("tx_byte", pushed_byte, exp_q.pop_front());
        if (lat_chk) check_int("latency", push_cyc - last_pop_cyc, cur_lat);
      end
    end
    if (rd_uart && rx_empty) check8("rd_while_empty", {7'd0, rd_uart}, 8'h00);
    if (wr_uart && tx_full) check8("wr_while_full", {7'd0, wr_uart}, 8'h00);
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? 8'h00 : rx_q[0];
  end

  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0 || busy) && n < max) begin
      @(negedge clk); #1;
      n++;
    end
    check_int("drain_timeout", n < max ? 1 : 0, 1);
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int len, input logic [7:0] resp, input int lat);
    cur_lat = lat;
    rx_q.push_back(b0);
    if (len > 1) rx_q.push_back(b1);
    if (len > 2) rx_q.push_back(b2);
    exp_q.push_back(resp);
    wait_drain(200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, nw;
    tbl[0] = '{8'h57, 8'h03, 8'hA5, 3, 8'h06, 2, 8'h00, 8'd0};
    tbl[1] = '{8'h52, 8'h03, 8'h00, 2, 8'hA5, 2, 8'h00, 8'd0};
    tbl[2] = '{8'h57, 8'h00, 8'h3C, 3, 8'h06, 2, 8'h3C, 8'd0};
    tbl[3] = '{8'h41, 8'h00, 8'h00, 1, 8'h15, 1, 8'h3C, 8'd1};
    tbl[4] = '{8'h52, 8'h10, 8'h00, 2, 8'h15, 2, 8'h3C, 8'd2};
    tbl[5] = '{8'h52, 8'h00, 8'h00, 2, 8'h3C, 2, 8'h3C, 8'd2};
    tbl[6] = '{8'h57, 8'h0F, 8'h15, 3, 8'h06, 2, 8'h3C, 8'd2};
    tbl[7] = '{8'h52, 8'h0F, 8'h00, 2, 8'h15, 2, 8'h3C, 8'd2};
    tbl[8] = '{8'h57, 8'hFF, 8'h11, 3, 8'h15, 2, 8'h3C, 8'd3};
    tbl[9] = '{8'h52, 8'h03, 8'h00, 2, 8'hA5, 2, 8'h3C, 8'd3};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check8("rst_busy", {7'd0, busy}, 8'h00);
    check8("rst_rd_uart", {7'd0, rd_uart}, 8'h00);
    check8("rst_wr_uart", {7'd0, wr_uart}, 8'h00);
    check8("rst_w_data", w_data, 8'h00);
    check8("rst_reg0", reg0, 8'h00);
    check8("rst_err_cnt", err_cnt, 8'h00);

    for (int i = 0; i < 10; i++) begin
      run_frame(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].len, tbl[i].resp, tbl[i].lat);
      check8($sformatf("vec%0d_reg0", i), reg0, tbl[i].reg0);
      check8($sformatf("vec%0d_err_cnt", i), err_cnt, tbl[i].err);
      check8($sformatf("vec%0d_busy", i), {7'd0, busy}, 8'h00);
    end

    // TX backpressure during a read
    lat_chk = 1'b0;
    tx_full = 1'b1;
    np = n_pops;
    nw = n_pushes;
    rx_q.push_back(8'h52);
    rx_q.push_back(8'h03);
    exp_q.push_back(8'hA5);
    repeat (20) @(negedge clk);
    #1;
    check_int("bp_pops_held", n_pops - np, 2);
    check_int("bp_no_push", n_pushes - nw, 0);
    check8("bp_wr_uart", {7'd0, wr_uart}, 8'h00);
    check8("bp_busy", {7'd0, busy}, 8'h01);
    tx_full = 1'b0;
    wait_drain(50);
    check_int("bp_one_push", n_pushes - nw, 1);
    check_int("bp_pops_total", n_pops - np, 2);
    lat_chk = 1'b1;

    // Inter-byte timeout abandons the write silently
    nw = n_pushes;
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h05);
    repeat (60) @(negedge clk);
    #1;
    check8("to_busy", {7'd0, busy}, 8'h00);
    check_int("to_no_push", n_pushes - nw, 0);
    check8("to_err_cnt", err_cnt, 8'd3);
    run_frame(8'h52, 8'h05, 8'h00, 2, 8'h00, 2);

    // Reset in the middle of a write frame
    nw = n_pushes;
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h02);
    repeat (4) @(negedge clk);
    #1;
    check8("mid_busy", {7'd0, busy}, 8'h01);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check8("post_rst_busy", {7'd0, busy}, 8'h00);
    check8("post_rst_reg0", reg0, 8'h00);
    check8("post_rst_err_cnt", err_cnt, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    check_int("post_rst_no_push", n_pushes - nw, 0);
    run_frame(8'h52, 8'h02, 8'h00, 2, 8'h00, 2);
    check_int("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
